de0_board_io: RTL and testbench

DE0_BOARD_IO -- requirements
Module: de0_board_io

---
 rtl/de0_board_pkg.sv | 21 ++
 rtl/de0_board_io_if.sv | 27 ++
 rtl/button_debounce.sv | 56 +++++
 rtl/de0_board_io.sv | 77 +++++++
 tb/tb_de0_board_io.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/de0_board_pkg.sv
// Shared constants for the DE0 board I/O block: hex-to-7-segment table and debounce default.
// Purely combinational helpers; no latency and no flow control.
package de0_board_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low segments ordered g..a; entry 0 sits in the low bits.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
        return SEG_LUT[nibble];
    endfunction

endpackage

// File: rtl/de0_board_io_if.sv
// Bundle of the board-facing button and display signals of de0_board_io.
// Wires only; master drives buttons and display requests, slave returns debounced state and segments.
interface de0_board_io_if #(
    parameter int NUM_BUTTONS = 3,
    parameter int NUM_DIGITS  = 4
) ();
    logic [NUM_BUTTONS-1:0]  BUTTON;
    logic [NUM_BUTTONS-1:0]  BTN_LEVEL;
    logic [NUM_BUTTONS-1:0]  BTN_PRESS;
    logic [NUM_BUTTONS-1:0]  BTN_RELEASE;
    logic                    DISP_LOAD;
    logic [4*NUM_DIGITS-1:0] DISP_VALUE;
    logic [NUM_DIGITS-1:0]   DISP_DP;
    logic [NUM_DIGITS-1:0]   DISP_BLANK;
    logic [7*NUM_DIGITS-1:0] HEX_D;
    logic [NUM_DIGITS-1:0]   HEX_DP;

    modport master (
        output BUTTON, DISP_LOAD, DISP_VALUE, DISP_DP, DISP_BLANK,
        input  BTN_LEVEL, BTN_PRESS, BTN_RELEASE, HEX_D, HEX_DP
    );

    modport slave (
        input  BUTTON, DISP_LOAD, DISP_VALUE, DISP_DP, DISP_BLANK,
        output BTN_LEVEL, BTN_PRESS, BTN_RELEASE, HEX_D, HEX_DP
    );
endinterface

// File: rtl/button_debounce.sv
// One pushbutton channel: 2-flop synchronizer plus stability counter; level/press/release registered.
// Clean edge reaches o_level DEBOUNCE_CYCLES+2 cycles after the raw input changes; no backpressure.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_n,
    output logic o_level,
    output logic o_press,
    output logic o_release
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic [CW-1:0] r_cnt;
    logic          w_differ;
    logic          w_accept;

    assign w_differ = r_sync2 ^ r_level;
    assign w_accept = w_differ && (r_cnt == CNT_LAST);

    // Synchronizer carries the pressed state (inverted pin) so reset means "released".
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= ~i_btn_n;
            r_sync2   <= r_sync1;
            r_press   <= w_accept && r_sync2;
            r_release <= w_accept && !r_sync2;
            if (w_accept) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else if (w_differ) begin
                r_cnt   <= r_cnt + 1'b1;
            end else begin
                r_cnt   <= '0;
            end
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
endmodule

// File: rtl/de0_board_io.sv
// DE0 board I/O: debounced pushbuttons and a load-strobed, registered 7-segment display (1-cycle load latency).
// Optional DE0_LEADING_ZERO_BLANK_EN blanks leading zero digits; no backpressure on any path.
module de0_board_io
    import de0_board_pkg::*;
#(
    parameter int NUM_BUTTONS     = 3,
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET,
    input  logic [NUM_BUTTONS-1:0]  BUTTON,
    output logic [NUM_BUTTONS-1:0]  BTN_LEVEL,
    output logic [NUM_BUTTONS-1:0]  BTN_PRESS,
    output logic [NUM_BUTTONS-1:0]  BTN_RELEASE,
    input  logic                    DISP_LOAD,
    input  logic [4*NUM_DIGITS-1:0] DISP_VALUE,
    input  logic [NUM_DIGITS-1:0]   DISP_DP,
    input  logic [NUM_DIGITS-1:0]   DISP_BLANK,
    output logic [7*NUM_DIGITS-1:0] HEX_D,
    output logic [NUM_DIGITS-1:0]   HEX_DP
);
    genvar g;
    generate
        for (g = 0; g < NUM_BUTTONS; g++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .i_clk    (CLOCK_50),
                .i_rst    (RESET),
                .i_btn_n  (BUTTON[g]),
                .o_level  (BTN_LEVEL[g]),
                .o_press  (BTN_PRESS[g]),
                .o_release(BTN_RELEASE[g])
            );
        end
    endgenerate

    logic [7*NUM_DIGITS-1:0] r_hex;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [7*NUM_DIGITS-1:0] w_hex_nxt;
    logic [NUM_DIGITS-1:0]   w_dp_nxt;
    logic [NUM_DIGITS-1:0]   w_lz_blank;
    logic                    w_zero_run;

    always_comb begin
        w_lz_blank = '0;
        w_zero_run = 1'b1;
`ifdef DE0_LEADING_ZERO_BLANK_EN
        // Walk down from the top digit; digit 0 is never reached, so it always shows.
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            w_zero_run    = w_zero_run && (DISP_VALUE[4*i +: 4] == 4'h0);
            w_lz_blank[i] = w_zero_run;
        end
`endif
        w_hex_nxt = '0;
        w_dp_nxt  = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_hex_nxt[7*i +: 7] = (DISP_BLANK[i] || w_lz_blank[i]) ? SEG_OFF
                                                                  : seg_encode(DISP_VALUE[4*i +: 4]);
            w_dp_nxt[i]         = ~(DISP_DP[i] && !DISP_BLANK[i]);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_hex <= '1;
            r_dp  <= '1;
        end else if (DISP_LOAD) begin
            r_hex <= w_hex_nxt;
            r_dp  <= w_dp_nxt;
        end
    end

    assign HEX_D  = r_hex;
    assign HEX_DP = r_dp;
endmodule

// File: tb/tb_de0_board_io.sv
// Directed bench for de0_board_io with DEBOUNCE_CYCLES=8; button events and display loads are scoreboarded.
module tb_de0_board_io;
    localparam int NB = 3;
    localparam int ND = 4;
    localparam int DC = 8;

    logic CLOCK_50 = 1'b0;
    logic RESET    = 1'b1;

    de0_board_io_if #(.NUM_BUTTONS(NB), .NUM_DIGITS(ND)) bus ();

    de0_board_io #(
        .NUM_BUTTONS    (NB),
        .NUM_DIGITS     (ND),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET      (RESET),
        .BUTTON     (bus.BUTTON),
        .BTN_LEVEL  (bus.BTN_LEVEL),
        .BTN_PRESS  (bus.BTN_PRESS),
        .BTN_RELEASE(bus.BTN_RELEASE),
        .DISP_LOAD  (bus.DISP_LOAD),
        .DISP_VALUE (bus.DISP_VALUE),
        .DISP_DP    (bus.DISP_DP),
        .DISP_BLANK (bus.DISP_BLANK),
        .HEX_D      (bus.HEX_D),
        .HEX_DP     (bus.HEX_DP)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        logic [NB-1:0] level;
    } evt_t;

    typedef struct {
        logic [7*ND-1:0] hex;
        logic [ND-1:0]   dp;
    } disp_t;

    evt_t  evq[$];
    disp_t dq[$];
    evt_t  mon_e;
    disp_t chk_d;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_evt(input int at, input logic [NB-1:0] p, input logic [NB-1:0] r,
                            input logic [NB-1:0] lvl);
        evt_t e;
        e.cyc = at; e.press = p; e.rel = r; e.level = lvl;
        evq.push_back(e);
    endtask

    // Drive a load, let one edge capture it, then compare at the following negedge.
    task automatic load_disp(input string tag, input logic [4*ND-1:0] val, input logic [ND-1:0] dp,
                             input logic [ND-1:0] blank, input logic [7*ND-1:0] exp_hex,
                             input logic [ND-1:0] exp_dp);
        disp_t d;
        d.hex = exp_hex; d.dp = exp_dp;
        dq.push_back(d);
        bus.DISP_VALUE = val;
        bus.DISP_DP    = dp;
        bus.DISP_BLANK = blank;
        bus.DISP_LOAD  = 1'b1;
        step();
        bus.DISP_LOAD  = 1'b0;
        @(negedge CLOCK_50);
        chk_d = dq.pop_front();
        check({tag, "_hex"}, bus.HEX_D, chk_d.hex);
        check({tag, "_dp"}, bus.HEX_DP, chk_d.dp);
    endtask

    // Every press/release pulse must match the head of the event queue, cycle-exact.
    always @(negedge CLOCK_50) begin
        if ((bus.BTN_PRESS | bus.BTN_RELEASE) !== '0) begin
            if (evq.size() == 0) begin
                check("unexpected_pulse", {bus.BTN_PRESS, bus.BTN_RELEASE}, '0);
            end else begin
                mon_e = evq.pop_front();
                check("evt_cycle", cyc, mon_e.cyc);
                check("evt_press", bus.BTN_PRESS, mon_e.press);
                check("evt_release", bus.BTN_RELEASE, mon_e.rel);
                check("evt_level", bus.BTN_LEVEL, mon_e.level);
            end
        end
    end

    int c;

    initial begin
        bus.BUTTON     = '1;
        bus.DISP_LOAD  = 1'b1;
        bus.DISP_VALUE = 16'h12AF;
        bus.DISP_DP    = 4'b1111;
        bus.DISP_BLANK = '0;
        RESET          = 1'b1;
        ticks(3);
        @(negedge CLOCK_50);
        check("rst_level", bus.BTN_LEVEL, '0);
        check("rst_press", bus.BTN_PRESS, '0);
        check("rst_release", bus.BTN_RELEASE, '0);
        check("rst_hex", bus.HEX_D, {7*ND{1'b1}});
        check("rst_dp", bus.HEX_DP, {ND{1'b1}});
        bus.DISP_LOAD = 1'b0;
        step();
        RESET = 1'b0;
        ticks(3);
        @(negedge CLOCK_50);
        check("post_rst_hex_dark", bus.HEX_D, {7*ND{1'b1}});
        check("post_rst_level", bus.BTN_LEVEL, '0);

        step();
        load_disp("hex12af", 16'h12AF, 4'b0100, 4'b0000,
                  {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011);
        step();
        bus.DISP_VALUE = 16'h0000;
        ticks(2);
        @(negedge CLOCK_50);
        check("hold_hex", bus.HEX_D, {7'h79, 7'h24, 7'h08, 7'h0E});
        check("hold_dp", bus.HEX_DP, 4'b1011);

        step();
        load_disp("blank", 16'h8888, 4'b1111, 4'b0010,
                  {7'h00, 7'h00, 7'h7F, 7'h00}, 4'b0010);
        step();
        load_disp("hex3c6d", 16'h3C6D, 4'b0000, 4'b0000,
                  {7'h30, 7'h46, 7'h02, 7'h21}, 4'b1111);
`ifdef DE0_LEADING_ZERO_BLANK_EN
        step();
        load_disp("lz0005", 16'h0005, 4'b0000, 4'b0000,
                  {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1111);
        step();
        load_disp("lz0000", 16'h0000, 4'b0000, 4'b0000,
                  {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111);
        step();
        load_disp("lz0300", 16'h0300, 4'b1000, 4'b0000,
                  {7'h7F, 7'h30, 7'h40, 7'h40}, 4'b0111);
`else
        step();
        load_disp("nolz0005", 16'h0005, 4'b0000, 4'b0000,
                  {7'h40, 7'h40, 7'h40, 7'h12}, 4'b1111);
        step();
        load_disp("nolz0000", 16'h0000, 4'b0000, 4'b0000,
                  {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111);
        step();
        load_disp("nolz0300", 16'h0300, 4'b1000, 4'b0000,
                  {7'h40, 7'h30, 7'h40, 7'h40}, 4'b0111);
`endif

        // Clean press on channel 0: accepted DC+2 edges after the pin change.
        step();
        c = cyc;
        bus.BUTTON[0] = 1'b0;
        push_evt(c + DC + 2, 3'b001, 3'b000, 3'b001);
        ticks(DC + 1);
        @(negedge CLOCK_50);
        check("btn0_level_early", bus.BTN_LEVEL, 3'b000);
        ticks(4);

        // Glitch on channel 1 shorter than the debounce window.
        bus.BUTTON[1] = 1'b0;
        ticks(5);
        bus.BUTTON[1] = 1'b1;
        ticks(2 * DC + 4);
        @(negedge CLOCK_50);
        check("glitch_level", bus.BTN_LEVEL, 3'b001);

        // Press channel 2, then release channels 0 and 2 together.
        step();
        c = cyc;
        bus.BUTTON[2] = 1'b0;
        push_evt(c + DC + 2, 3'b100, 3'b000, 3'b101);
        ticks(DC + 5);
        c = cyc;
        bus.BUTTON[0] = 1'b1;
        bus.BUTTON[2] = 1'b1;
        push_evt(c + DC + 2, 3'b000, 3'b101, 3'b000);
        ticks(DC + 5);
        @(negedge CLOCK_50);
        check("release_level", bus.BTN_LEVEL, 3'b000);

        // Reset in the middle of a press; button stays held through reset.
        step();
        bus.BUTTON[0] = 1'b0;
        ticks(5);
        RESET = 1'b1;
        ticks(3);
        @(negedge CLOCK_50);
        check("midrst_level", bus.BTN_LEVEL, '0);
        check("midrst_press", bus.BTN_PRESS, '0);
        check("midrst_hex", bus.HEX_D, {7*ND{1'b1}});
        check("midrst_dp", bus.HEX_DP, {ND{1'b1}});
        step();
        RESET = 1'b0;
        c = cyc;
        push_evt(c + DC + 2, 3'b001, 3'b000, 3'b001);
        ticks(DC + 6);
        @(negedge CLOCK_50);
        check("after_rst_level", bus.BTN_LEVEL, 3'b001);

        check("missing_events", evq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
